// File: rtl/irq_event_coalescer.sv
// irq_event_coalescer: edge-detects raw event levels, keeps a sticky W1C status
// register, and coalesces detections (count threshold / timeout / hold-off)
// into a one-cycle pulse vector for the IRQ generator status input.
module irq_event_coalescer #(
  parameter int STATUS_W = 32,
  parameter int CNT_W    = 8,
  parameter int TMR_W    = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                enable_i,
  input  logic [1:0]          edge_mode_i,
  input  logic [STATUS_W-1:0] event_i,
  input  logic [CNT_W-1:0]    thresh_i,
  input  logic [TMR_W-1:0]    timeout_i,
  input  logic [TMR_W-1:0]    holdoff_i,
  input  logic                status_wr_i,
  input  logic [STATUS_W-1:0] status_w1c_i,
  output logic [STATUS_W-1:0] status_o,
  output logic [STATUS_W-1:0] pulse_o,
  output logic                pending_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLDOFF = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [STATUS_W-1:0] prev_q, prev_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [STATUS_W-1:0] pulse_q, pulse_d;
  logic [STATUS_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [TMR_W-1:0]    hcnt_q, hcnt_d;
  logic                pending_q, pending_d;

  logic [STATUS_W-1:0] det, acc_n;
  logic [CNT_W-1:0]    cnt_n, eff_thr;
  logic                any_det, flush;

  // Edge/level detection against the previous-cycle event levels.
  always_comb begin
    det = '0;
    if (enable_i) begin
      unique case (edge_mode_i)
        2'd0: det = event_i & ~prev_q;
        2'd1: det = ~event_i & prev_q;
        2'd2: det = event_i ^ prev_q;
        default: det = event_i;
      endcase
    end
  end

  assign any_det = |det;
  assign acc_n   = acc_q | det;
  // Counts detection cycles, not bits; sticks at all-ones.
  assign cnt_n   = (any_det && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign eff_thr = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

  // Next-state: status, coalescing FSM, accumulator and counters.
  always_comb begin
    prev_d    = event_i;
    status_d  = (status_q & ~(status_wr_i ? status_w1c_i : '0)) | det;
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    hcnt_d    = hcnt_q;
    pulse_d   = '0;
    flush     = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmr_d   = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_det) begin
            if (cnt_n >= eff_thr) begin
              flush = 1'b1;
            end else begin
              state_d = ACCUM;
              acc_d   = acc_n;
              cnt_d   = cnt_n;
              tmr_d   = timeout_i;
            end
          end
        end
        ACCUM: begin
          if ((cnt_n >= eff_thr) || ((timeout_i != '0) && (tmr_q == TMR_W'(1)))) begin
            flush = 1'b1;
          end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            tmr_d = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
          end
        end
        HOLDOFF: begin
          // Keep collecting; the held bits go out once hold-off ends.
          acc_d  = acc_n;
          cnt_d  = cnt_n;
          hcnt_d = (hcnt_q != '0) ? hcnt_q - TMR_W'(1) : hcnt_q;
          if (hcnt_q <= TMR_W'(1)) begin
            state_d = (acc_n != '0) ? ACCUM : IDLE;
            tmr_d   = timeout_i;
          end
        end
        default: state_d = IDLE;
      endcase

      // Flush takes this cycle's detections too, so nothing is dropped.
      if (flush) begin
        pulse_d = acc_n;
        acc_d   = '0;
        cnt_d   = '0;
        if (holdoff_i != '0) begin
          state_d = HOLDOFF;
          hcnt_d  = holdoff_i;
        end else begin
          state_d = IDLE;
        end
      end
    end

    pending_d = |acc_d;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      status_q  <= '0;
      pulse_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      hcnt_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      status_q  <= status_d;
      pulse_q   <= pulse_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      hcnt_q    <= hcnt_d;
      pending_q <= pending_d;
    end
  end

  assign status_o  = status_q;
  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_irq_event_coalescer.sv
// Directed table-driven bench for irq_event_coalescer plus hand sequences
// for timeout, hold-off, enable drop and mid-accumulation reset.
module tb_irq_event_coalescer;

  logic        clk = 1'b0;
  logic        arst;
  logic        enable;
  logic [1:0]  edge_mode;
  logic [31:0] event_v;
  logic [7:0]  thresh;
  logic [15:0] timeout, holdoff;
  logic        status_wr;
  logic [31:0] status_w1c;
  logic [31:0] status, pulse;
  logic        pending;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  irq_event_coalescer dut (
    .clk_i(clk), .arst_i(arst), .enable_i(enable), .edge_mode_i(edge_mode),
    .event_i(event_v), .thresh_i(thresh), .timeout_i(timeout), .holdoff_i(holdoff),
    .status_wr_i(status_wr), .status_w1c_i(status_w1c),
    .status_o(status), .pulse_o(pulse), .pending_o(pending), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ev;
    logic [1:0]  mode;
    logic [7:0]  thr;
    logic        wr;
    logic [31:0] w1c;
    logic [31:0] x_pulse;
    logic [31:0] x_status;
    logic [1:0]  x_state;
    logic        x_pend;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic [31:0] ev, logic [1:0] mode, logic [7:0] thr,
                              logic wr, logic [31:0] w1c, logic [31:0] xp,
                              logic [31:0] xs, logic [1:0] xst, logic xpd);
    vec_t v;
    v.ev = ev; v.mode = mode; v.thr = thr; v.wr = wr; v.w1c = w1c;
    v.x_pulse = xp; v.x_status = xs; v.x_state = xst; v.x_pend = xpd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] xp, input logic [31:0] xs,
                         input logic [1:0] xst, input logic xpd);
    chk({tag, ".pulse"},   pulse,          xp);
    chk({tag, ".status"},  status,         xs);
    chk({tag, ".state"},   {30'd0, state}, {30'd0, xst});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, xpd});
  endtask

  initial begin
    // Vectors: inputs for one cycle, outputs expected after that edge.
    // Rising-edge single flush (thr 1).
    tbl[0]  = mk(32'h0,  2'd0, 8'd1, 1'b0, 32'h0, 32'h0,  32'h0,  2'd0, 1'b0);
    tbl[1]  = mk(32'h8,  2'd0, 8'd1, 1'b0, 32'h0, 32'h8,  32'h8,  2'd0, 1'b0);
    tbl[2]  = mk(32'h8,  2'd0, 8'd1, 1'b0, 32'h0, 32'h0,  32'h8,  2'd0, 1'b0);
    tbl[3]  = mk(32'h0,  2'd0, 8'd1, 1'b0, 32'h0, 32'h0,  32'h8,  2'd0, 1'b0);
    tbl[4]  = mk(32'h0,  2'd0, 8'd1, 1'b1, 32'h8, 32'h0,  32'h0,  2'd0, 1'b0);
    // Threshold 3: three detection cycles coalesce into one pulse.
    tbl[5]  = mk(32'h1,  2'd0, 8'd3, 1'b0, 32'h0, 32'h0,  32'h1,  2'd1, 1'b1);
    tbl[6]  = mk(32'h1,  2'd0, 8'd3, 1'b0, 32'h0, 32'h0,  32'h1,  2'd1, 1'b1);
    tbl[7]  = mk(32'h3,  2'd0, 8'd3, 1'b0, 32'h0, 32'h0,  32'h3,  2'd1, 1'b1);
    tbl[8]  = mk(32'h3,  2'd0, 8'd3, 1'b0, 32'h0, 32'h0,  32'h3,  2'd1, 1'b1);
    tbl[9]  = mk(32'h7,  2'd0, 8'd3, 1'b0, 32'h0, 32'h7,  32'h7,  2'd0, 1'b0);
    tbl[10] = mk(32'h7,  2'd0, 8'd3, 1'b0, 32'h0, 32'h0,  32'h7,  2'd0, 1'b0);
    // W1C: clear bit 2, then clear 0x3 while bit 0 re-detects (set wins).
    tbl[11] = mk(32'h6,  2'd0, 8'd1, 1'b1, 32'h4, 32'h0,  32'h3,  2'd0, 1'b0);
    tbl[12] = mk(32'h7,  2'd0, 8'd1, 1'b1, 32'h3, 32'h1,  32'h1,  2'd0, 1'b0);
    tbl[13] = mk(32'h7,  2'd0, 8'd1, 1'b0, 32'h0, 32'h0,  32'h1,  2'd0, 1'b0);
    // Both-edge mode: fall then rise each pulse.
    tbl[14] = mk(32'h6,  2'd2, 8'd1, 1'b0, 32'h0, 32'h1,  32'h1,  2'd0, 1'b0);
    tbl[15] = mk(32'h6,  2'd2, 8'd1, 1'b0, 32'h0, 32'h0,  32'h1,  2'd0, 1'b0);
    tbl[16] = mk(32'h7,  2'd2, 8'd1, 1'b0, 32'h0, 32'h1,  32'h1,  2'd0, 1'b0);
    // Falling mode.
    tbl[17] = mk(32'h7,  2'd1, 8'd1, 1'b0, 32'h0, 32'h0,  32'h1,  2'd0, 1'b0);
    tbl[18] = mk(32'h5,  2'd1, 8'd1, 1'b0, 32'h0, 32'h2,  32'h3,  2'd0, 1'b0);
    // Level mode: every high cycle detects.
    tbl[19] = mk(32'h5,  2'd3, 8'd1, 1'b0, 32'h0, 32'h5,  32'h7,  2'd0, 1'b0);
    tbl[20] = mk(32'h5,  2'd3, 8'd1, 1'b0, 32'h0, 32'h5,  32'h7,  2'd0, 1'b0);
    tbl[21] = mk(32'h0,  2'd3, 8'd1, 1'b0, 32'h0, 32'h0,  32'h7,  2'd0, 1'b0);
    // Threshold 0 behaves as 1.
    tbl[22] = mk(32'h10, 2'd0, 8'd0, 1'b0, 32'h0, 32'h10, 32'h17, 2'd0, 1'b0);
    tbl[23] = mk(32'h10, 2'd0, 8'd0, 1'b0, 32'h0, 32'h0,  32'h17, 2'd0, 1'b0);

    arst = 1'b1; enable = 1'b1; edge_mode = 2'd0; event_v = '0;
    thresh = 8'd1; timeout = '0; holdoff = '0; status_wr = 1'b0; status_w1c = '0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    #4;

    for (int i = 0; i < 24; i++) begin
      event_v = tbl[i].ev; edge_mode = tbl[i].mode; thresh = tbl[i].thr;
      status_wr = tbl[i].wr; status_w1c = tbl[i].w1c;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].x_pulse, tbl[i].x_status,
              tbl[i].x_state, tbl[i].x_pend);
    end
    status_wr = 1'b0; status_w1c = '0; edge_mode = 2'd0;

    // Timeout 5: single edge flushes T+1 cycles after detection.
    thresh = 8'd10; timeout = 16'd5; event_v = 32'h30;
    tick();
    chk_all("tmo.start", 32'h0, 32'h37, 2'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("tmo.wait%0d.pulse", k), pulse, 32'h0);
      chk($sformatf("tmo.wait%0d.state", k), {30'd0, state}, 32'd1);
    end
    tick();
    chk_all("tmo.flush", 32'h20, 32'h37, 2'd0, 1'b0);
    tick();
    chk("tmo.after.pulse", pulse, 32'h0);

    // Hold-off 4: second edge is held and released after hold-off.
    thresh = 8'd1; timeout = '0; holdoff = 16'd4; event_v = 32'h31;
    tick();
    chk_all("hold.first", 32'h1, 32'h37, 2'd2, 1'b0);
    tick();
    chk_all("hold.h3", 32'h0, 32'h37, 2'd2, 1'b0);
    event_v = 32'h33;
    tick();
    chk_all("hold.merge", 32'h0, 32'h37, 2'd2, 1'b1);
    tick();
    chk_all("hold.h1", 32'h0, 32'h37, 2'd2, 1'b1);
    tick();
    chk_all("hold.accum", 32'h0, 32'h37, 2'd1, 1'b1);
    tick();
    chk_all("hold.release", 32'h2, 32'h37, 2'd2, 1'b0);
    holdoff = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold.drain%0d.state", k), {30'd0, state}, 32'd2);
    end
    tick();
    chk_all("hold.idle", 32'h0, 32'h37, 2'd0, 1'b0);

    // Enable drop mid-accumulation: no pulse, status held, prev still tracks.
    thresh = 8'd10; event_v = 32'h37;
    tick();
    chk_all("en.accum", 32'h0, 32'h37, 2'd1, 1'b1);
    enable = 1'b0; event_v = 32'h3F;
    tick();
    chk_all("en.low", 32'h0, 32'h37, 2'd0, 1'b0);
    enable = 1'b1;
    tick();
    chk_all("en.back", 32'h0, 32'h37, 2'd0, 1'b0);

    // Async reset mid-accumulation clears immediately without a pulse.
    event_v = 32'h7F;
    tick();
    chk_all("rst.accum", 32'h0, 32'h77, 2'd1, 1'b1);
    #2 arst = 1'b1; event_v = '0;
    #1;
    chk_all("rst.async", 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    arst = 1'b0;
    tick();
    chk_all("rst.after", 32'h0, 32'h0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
